data_mem_responder: RTL

Multi-cycle, byte-addressable RV32I data-memory responder: the memory end of the CPU's load/store interface. It accepts one request at a time over a valid/ready handshake, waits a programmable latency, then returns one response pulse carrying load data or an error flag. It supports byte, halfword and word accesses coded by funct3. It takes the place of the single-cycle data memory when the pipelined core's memory stage runs against a slow memory.

---
 rtl/data_mem_responder.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/data_mem_responder.sv
// data_mem_responder: multi-cycle byte-addressable RV32I data memory.
// Accepts one load/store at a time, waits LATENCY cycles, and then emits a
// single response pulse carrying extended load data or an error flag.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | req_ready=1, waiting for a request
// BUSY  | request latched, counting down the access latency
// RESP  | resp_valid=1 for one cycle, response registers hold the result
module data_mem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_func3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        busy
);

    localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);
    localparam logic [32:0] ADDR_LIMIT = 33'(4 * DEPTH_WORDS);

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;

    logic             we_q;
    logic [2:0]       func3_q;
    logic [31:0]      addr_q;
    logic [31:0]      wdata_q;

    logic [31:0]      mem [DEPTH_WORDS];

    logic [IDX_W-1:0] word_idx;
    logic [31:0]      rd_word;
    logic [7:0]       rd_byte;
    logic [15:0]      rd_half;
    logic [31:0]      load_data;
    logic             acc_err;
    logic [3:0]       wr_mask;
    logic [31:0]      wr_data;
    logic             access_edge;
    logic             mem_we;

    assign req_ready = (state == IDLE);
    assign busy      = (state != IDLE);

    assign word_idx    = addr_q[IDX_W+1:2];
    assign rd_word     = mem[word_idx];
    assign access_edge = (state == BUSY) && (cnt == '0);
    assign mem_we      = access_edge && we_q && !acc_err;

    // Decode the latched request: legality, lane selection and load extension.
    always_comb begin
        acc_err   = 1'b0;
        wr_mask   = 4'b0000;
        wr_data   = wdata_q;
        load_data = 32'h0;

        case (addr_q[1:0])
            2'd0:    rd_byte = rd_word[7:0];
            2'd1:    rd_byte = rd_word[15:8];
            2'd2:    rd_byte = rd_word[23:16];
            default: rd_byte = rd_word[31:24];
        endcase
        rd_half = addr_q[1] ? rd_word[31:16] : rd_word[15:0];

        case (func3_q)
            F3_B, F3_BU: begin
                wr_mask = 4'b0001 << addr_q[1:0];
                wr_data = {4{wdata_q[7:0]}};
            end
            F3_H, F3_HU: begin
                if (addr_q[0]) acc_err = 1'b1;
                wr_mask = addr_q[1] ? 4'b1100 : 4'b0011;
                wr_data = {2{wdata_q[15:0]}};
            end
            F3_W: begin
                if (addr_q[1:0] != 2'b00) acc_err = 1'b1;
                wr_mask = 4'b1111;
            end
            default: acc_err = 1'b1;
        endcase

        // Unsigned variants exist only for loads.
        if (we_q && func3_q[2]) acc_err = 1'b1;
        if ({1'b0, addr_q} >= ADDR_LIMIT) acc_err = 1'b1;

        case (func3_q)
            F3_B:    load_data = {{24{rd_byte[7]}}, rd_byte};
            F3_BU:   load_data = {24'h0, rd_byte};
            F3_H:    load_data = {{16{rd_half[15]}}, rd_half};
            F3_HU:   load_data = {16'h0, rd_half};
            F3_W:    load_data = rd_word;
            default: load_data = 32'h0;
        endcase
    end

    // Request/response FSM with registered response outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            we_q       <= 1'b0;
            func3_q    <= 3'b000;
            addr_q     <= 32'h0;
            wdata_q    <= 32'h0;
            resp_valid <= 1'b0;
            resp_rdata <= 32'h0;
            resp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    resp_valid <= 1'b0;
                    if (req_valid) begin
                        we_q    <= req_we;
                        func3_q <= req_func3;
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                        cnt     <= CNT_INIT;
                        state   <= BUSY;
                    end
                end
                BUSY: begin
                    if (cnt == '0) begin
                        state      <= RESP;
                        resp_valid <= 1'b1;
                        resp_err   <= acc_err;
                        resp_rdata <= (acc_err || we_q) ? 32'h0 : load_data;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                RESP: begin
                    resp_valid <= 1'b0;
                    state      <= IDLE;
                end
                default: begin
                    resp_valid <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end

    // Byte-lane write into the array; contents are intentionally not reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (wr_mask[i]) mem[word_idx][8*i +: 8] <= wr_data[8*i +: 8];
            end
        end
    end

endmodule
